// File: rtl/botonera_updown_pkg.sv
// Shared types and default constants for the pushbutton conditioner.
package botonera_pkg;

  // Debounce FSM states, one FSM per button.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } btn_state_t;

  // Defaults: 10 ms debounce, 0.5 s repeat delay, 0.1 s repeat period at 50 MHz.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Button slots used by the top-level generate loop.
  localparam int NUM_BTN  = 2;
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;

  // Counter width large enough to hold the biggest timing parameter.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/botonera_updown_if.sv
// Button bus: raw pushbutton inputs and conditioned command/level outputs.
// master = board/bench side driving the buttons, slave = conditioner.
interface botonera_if;
  logic btn_up_raw;
  logic btn_down_raw;
  logic up;
  logic down;
  logic up_lvl;
  logic down_lvl;

  modport master (
    output btn_up_raw, btn_down_raw,
    input  up, down, up_lvl, down_lvl
  );

  modport slave (
    input  btn_up_raw, btn_down_raw,
    output up, down, up_lvl, down_lvl
  );
endinterface

// File: rtl/botonera_updown_debounce_btn.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM with run counter,
// registered debounced level and a raw (combinational) press event that the
// top registers. Optional auto-repeat enabled by macro BOTONERA_REPEAT_EN.
module debounce_btn
  import botonera_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_other_lvl,
  output logic o_lvl,
  output logic o_press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  btn_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_lvl;
  logic          w_sync;
  logic          w_press_evt;
  logic          w_rep_fire;

  assign w_sync = r_sync[1];

  // Two-flop synchroniser for the asynchronous, bouncing button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], i_raw};
  end

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive equal samples; any contrary sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sync) begin
            r_state <= WAIT_PRESS;
            r_cnt   <= CNT_ONE;
          end
        end
        WAIT_PRESS: begin
          if (!w_sync) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= PRESSED;
            r_lvl   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_sync) begin
            r_state <= WAIT_RELEASE;
            r_cnt   <= CNT_ONE;
          end
        end
        WAIT_RELEASE: begin
          if (w_sync) begin
            r_state <= PRESSED;
          end else if (r_cnt == DB_LAST) begin
            r_state <= IDLE;
            r_lvl   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_lvl   <= 1'b0;
        end
      endcase
    end
  end

  // Press event is decoded from the edge that will enter PRESSED, so the
  // top's output register shows the pulse in the cycle right after it.
  assign w_press_evt = (r_state == WAIT_PRESS) && w_sync && (r_cnt == DB_LAST);

`ifdef BOTONERA_REPEAT_EN
  // Repeat fires one cycle early for the same reason as the press event;
  // after a fire the counter is rewound so the next fire is REPEAT_PERIOD later.
  localparam logic [CW-1:0] RPT_FIRE   = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CW-1:0] r_rcnt;
  logic          w_rep_hit;

  assign w_rep_hit  = (r_state == PRESSED) && (r_rcnt == RPT_FIRE);
  assign w_rep_fire = w_rep_hit && !i_other_lvl;

  // Repeat counter: clears on entry to PRESSED and in IDLE, runs in PRESSED,
  // freezes in WAIT_RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt <= '0;
    end else if (w_press_evt || ((r_state == WAIT_RELEASE) && w_sync)) begin
      r_rcnt <= '0;
    end else if (r_state == IDLE) begin
      r_rcnt <= '0;
    end else if (r_state == PRESSED) begin
      if (w_rep_hit) r_rcnt <= RPT_RELOAD;
      else           r_rcnt <= r_rcnt + 1'b1;
    end
  end
`else
  logic w_unused_other;
  assign w_unused_other = i_other_lvl;
  assign w_rep_fire     = 1'b0;
`endif

  assign o_lvl   = r_lvl;
  assign o_press = w_press_evt | w_rep_fire;

endmodule

// File: rtl/botonera_updown.sv
// Pushbutton conditioner for the up/down counter: two debounced channels,
// simultaneous-press suppression and registered single-cycle command pulses.
// Optional auto-repeat enabled by macro BOTONERA_REPEAT_EN.
module botonera_updown
  import botonera_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic       clk,
  input logic       rst_n,
  botonera_if.slave bus
);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_lvl;
  logic [NUM_BTN-1:0] w_press;
  logic               r_up;
  logic               r_down;

  assign w_raw[BTN_UP]   = bus.btn_up_raw;
  assign w_raw[BTN_DOWN] = bus.btn_down_raw;

  // One conditioning channel per button; each sees the other's level so
  // repeats can be held off while both buttons are down.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_btn #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_btn (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_raw      (w_raw[g]),
      .i_other_lvl(w_lvl[NUM_BTN-1-g]),
      .o_lvl      (w_lvl[g]),
      .o_press    (w_press[g])
    );
  end

  // Command pulses: events on both buttons at once cancel each other, which
  // also guarantees up and down are never high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
    end else begin
      r_up   <= w_press[BTN_UP]   & ~w_press[BTN_DOWN];
      r_down <= w_press[BTN_DOWN] & ~w_press[BTN_UP];
    end
  end

  assign bus.up       = r_up;
  assign bus.down     = r_down;
  assign bus.up_lvl   = w_lvl[BTN_UP];
  assign bus.down_lvl = w_lvl[BTN_DOWN];

endmodule
